pixel_readout: RTL and testbench

- Responder end of the pixel control sequence: consumes the erase/expose/convert/read0..read3 strobes produced by the pixel sequencer.
- During convert it drives the ADC ramp code to the pixel array.
- During each read phase it samples the shared pixel data bus, tags the sample with its pixel index, buffers it in a small FIFO and streams it out on a valid/ready interface toward the frame/host logic.

---
 rtl/pixel_readout.sv | 228 ++++++++++++++++++++++
 tb/tb_pixel_readout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout.sv
// pixel_readout: responder for the pixel sequencer strobes.
// Decodes the erase/expose/convert/readN strobes into a registered phase,
// drives the ADC ramp while converting, captures one pixel sample per read
// strobe into a small FIFO and streams it out over valid/ready.
module pixel_readout #(
   parameter int DW          = 8,
   parameter int DEPTH       = 4,
   parameter int READ_SAMPLE = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          erase,
   input  logic          expose,
   input  logic          convert,
   input  logic          read0,
   input  logic          read1,
   input  logic          read2,
   input  logic          read3,
   input  logic [DW-1:0] pix_data,
   output logic [DW-1:0] dac_code,
   output logic          dac_en,
   output logic [DW-1:0] out_data,
   output logic [1:0]    out_pix,
   output logic          out_sof,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    frame_cnt,
   output logic          overrun,
   output logic          proto_err
);

   localparam int AW = $clog2(DEPTH);
   // counter value seen on the READ_SAMPLE-th (1-based) cycle of a strobe
   localparam logic [7:0]  SAMPLE_CNT = 8'(READ_SAMPLE - 1);
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ERASE  = 3'd1,
      S_EXPOSE = 3'd2,
      S_CONV   = 3'd3,
      S_READ   = 3'd4
   } state_t;

   state_t        r_state;
   logic [1:0]    r_idx;
   logic [7:0]    r_cnt;
   logic [DW-1:0] r_dac_code;
   logic          r_dac_en;
   logic [DW-1:0] r_mem_data [DEPTH];
   logic [1:0]    r_mem_pix  [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic [DW-1:0] r_out_data;
   logic [1:0]    r_out_pix;
   logic          r_out_sof;
   logic          r_out_valid;
   logic [7:0]    r_frame_cnt;
   logic          r_overrun;
   logic          r_proto_err;

   state_t        w_next_state;
   logic [1:0]    w_next_idx;
   logic [2:0]    w_nstrobe;
   logic          w_multi;
   logic          w_same;
   logic [7:0]    w_cnt_next;
   logic          w_push;
   logic          w_short;
   logic          w_erase_entry;
   logic          w_pop;
   logic          w_full;
   logic          w_push_ok;
   logic          w_drop;
   logic [AW:0]   w_count_next;
   logic [AW-1:0] w_rptr_next;
   logic [DW-1:0] w_head_data;
   logic [1:0]    w_head_pix;

   // Strobe decode: next phase, read index, and protocol violations.
   always_comb begin
      w_nstrobe = {2'b00, erase} + {2'b00, expose} + {2'b00, convert}
                + {2'b00, read0} + {2'b00, read1} + {2'b00, read2} + {2'b00, read3};
      w_multi      = (w_nstrobe > 3'd1);
      w_next_idx   = r_idx;
      w_next_state = S_IDLE;
      if (w_multi) begin
         w_next_state = S_IDLE;
      end else if (erase) begin
         w_next_state = S_ERASE;
      end else if (expose) begin
         w_next_state = S_EXPOSE;
      end else if (convert) begin
         w_next_state = S_CONV;
      end else if (read0 | read1 | read2 | read3) begin
         w_next_state = S_READ;
         w_next_idx   = read3 ? 2'd3 : (read2 ? 2'd2 : (read1 ? 2'd1 : 2'd0));
      end else begin
         w_next_state = S_IDLE;
      end
      w_same = (w_next_state == r_state) &&
               ((w_next_state != S_READ) || (w_next_idx == r_idx));
      if ((w_next_state == S_IDLE) || !w_same) begin
         w_cnt_next = 8'd0;
      end else if (r_cnt == 8'd255) begin
         w_cnt_next = 8'd255;
      end else begin
         w_cnt_next = r_cnt + 8'd1;
      end
      w_push  = (w_next_state == S_READ) && (w_cnt_next == SAMPLE_CNT);
      // a read strobe that ends before its sample cycle never captured
      w_short = (r_state == S_READ) && (r_cnt < SAMPLE_CNT) &&
                !((w_next_state == S_READ) && (w_next_idx == r_idx));
      w_erase_entry = (w_next_state == S_ERASE) && (r_state != S_ERASE);
   end

   // FIFO bookkeeping and look-ahead of the head entry after this edge.
   always_comb begin
      w_pop       = r_out_valid & out_ready;
      w_full      = (r_count == FULL_CNT);
      w_push_ok   = w_push && (!w_full || w_pop);
      w_drop      = w_push && w_full && !w_pop;
      w_rptr_next = w_pop ? (r_rptr + {{(AW-1){1'b0}}, 1'b1}) : r_rptr;
      if (w_push_ok && !w_pop) begin
         w_count_next = r_count + {{AW{1'b0}}, 1'b1};
      end else if (!w_push_ok && w_pop) begin
         w_count_next = r_count - {{AW{1'b0}}, 1'b1};
      end else begin
         w_count_next = r_count;
      end
      // the slot being written this edge may become the head immediately
      if (w_push_ok && (r_wptr == w_rptr_next)) begin
         w_head_data = pix_data;
         w_head_pix  = w_next_idx;
      end else begin
         w_head_data = r_mem_data[w_rptr_next];
         w_head_pix  = r_mem_pix[w_rptr_next];
      end
   end

   // Phase FSM, strobe counter, ramp generator and sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= 2'd0;
         r_cnt       <= 8'd0;
         r_dac_code  <= '0;
         r_dac_en    <= 1'b0;
         r_frame_cnt <= 8'd0;
         r_overrun   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
         r_cnt   <= w_cnt_next;
         r_dac_en <= (w_next_state == S_CONV);
         if ((w_next_state == S_CONV) && (r_state == S_CONV)) begin
            if (r_dac_code != {DW{1'b1}}) begin
               r_dac_code <= r_dac_code + {{(DW-1){1'b0}}, 1'b1};
            end
         end else begin
            r_dac_code <= '0;
         end
         if (w_push_ok && (w_next_idx == 2'd3)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
         if (w_erase_entry) begin
            r_overrun   <= 1'b0;
            r_proto_err <= 1'b0;
         end else begin
            if (w_drop) begin
               r_overrun <= 1'b1;
            end
            if (w_multi || w_short) begin
               r_proto_err <= 1'b1;
            end
         end
      end
   end

   // FIFO storage, pointers and the registered output beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_pix[i]  <= 2'd0;
         end
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_pix   <= 2'd0;
         r_out_sof   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem_data[r_wptr] <= pix_data;
            r_mem_pix[r_wptr]  <= w_next_idx;
            r_wptr             <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
         end
         r_rptr  <= w_rptr_next;
         r_count <= w_count_next;
         if (w_count_next != '0) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head_data;
            r_out_pix   <= w_head_pix;
            r_out_sof   <= (w_head_pix == 2'd0);
         end else begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_pix   <= 2'd0;
            r_out_sof   <= 1'b0;
         end
      end
   end

   assign dac_code  = r_dac_code;
   assign dac_en    = r_dac_en;
   assign out_data  = r_out_data;
   assign out_pix   = r_out_pix;
   assign out_sof   = r_out_sof;
   assign out_valid = r_out_valid;
   assign frame_cnt = r_frame_cnt;
   assign overrun   = r_overrun;
   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: full frame, ramp, backpressure,
// illegal strobes, full-FIFO push/pop and asynchronous reset.
module tb_pixel_readout;

   logic       clk = 1'b0;
   logic       reset;
   logic       erase, expose, convert, read0, read1, read2, read3;
   logic [7:0] pix_data;
   logic [7:0] dac_code;
   logic       dac_en;
   logic [7:0] out_data;
   logic [1:0] out_pix;
   logic       out_sof;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] frame_cnt;
   logic       overrun;
   logic       proto_err;

   int n_cmp = 0;
   int n_err = 0;
   logic [10:0] beats [$];

   pixel_readout #(.DW(8), .DEPTH(4), .READ_SAMPLE(3)) dut (
      .clk(clk), .reset(reset),
      .erase(erase), .expose(expose), .convert(convert),
      .read0(read0), .read1(read1), .read2(read2), .read3(read3),
      .pix_data(pix_data),
      .dac_code(dac_code), .dac_en(dac_en),
      .out_data(out_data), .out_pix(out_pix), .out_sof(out_sof),
      .out_valid(out_valid), .out_ready(out_ready),
      .frame_cnt(frame_cnt), .overrun(overrun), .proto_err(proto_err)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   // Record every accepted output beat as {sof, pix, data}.
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) begin
         beats.push_back({out_sof, out_pix, out_data});
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic expect_beat(input string tag, input logic sof, input logic [1:0] pix,
                              input logic [7:0] data);
      logic [10:0] b;
      if (beats.size() != 0) b = beats.pop_front();
      else b = 11'bx;
      check(tag, {21'd0, b}, {21'd0, sof, pix, data});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int which, input int len, input logic [7:0] d);
      pix_data = d;
      case (which)
         0: erase = 1'b1;
         1: expose = 1'b1;
         2: convert = 1'b1;
         3: read0 = 1'b1;
         4: read1 = 1'b1;
         5: read2 = 1'b1;
         default: read3 = 1'b1;
      endcase
      tick(len);
      {erase, expose, convert, read0, read1, read2, read3} = 7'd0;
   endtask

   task automatic reads(input logic [7:0] d0, d1, d2, d3);
      strobe(3, 5, d0);
      strobe(4, 5, d1);
      strobe(5, 5, d2);
      strobe(6, 5, d3);
   endtask

   task automatic frame(input logic [7:0] d0, d1, d2, d3);
      strobe(0, 3, 8'h00);
      strobe(1, 3, 8'h00);
      strobe(2, 3, 8'h00);
      reads(d0, d1, d2, d3);
      tick(2);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {erase, expose, convert, read0, read1, read2, read3} = 7'd0;
      pix_data = 8'h00;
      tick(2);
      reset = 1'b0;
      beats.delete();
   endtask

   initial begin
      reset = 1'b1;
      {erase, expose, convert, read0, read1, read2, read3} = 7'd0;
      pix_data  = 8'h00;
      out_ready = 1'b1;
      tick(2);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);
      check("rst_sof", {31'd0, out_sof}, 32'd0);
      check("rst_dac", {23'd0, dac_en, dac_code}, 32'd0);
      check("rst_flags", {22'd0, frame_cnt, overrun, proto_err}, 32'd0);
      reset = 1'b0;

      // Full sequence with the nominal phase lengths.
      strobe(0, 5, 8'h00);
      strobe(1, 255, 8'h00);
      strobe(2, 255, 8'h00);
      reads(8'h11, 8'h22, 8'h33, 8'h44);
      tick(6);
      check("full_nbeats", beats.size(), 32'd4);
      expect_beat("full_b0", 1'b1, 2'd0, 8'h11);
      expect_beat("full_b1", 1'b0, 2'd1, 8'h22);
      expect_beat("full_b2", 1'b0, 2'd2, 8'h33);
      expect_beat("full_b3", 1'b0, 2'd3, 8'h44);
      check("full_fcnt", {24'd0, frame_cnt}, 32'd1);
      check("full_ovr", {31'd0, overrun}, 32'd0);
      check("full_perr", {31'd0, proto_err}, 32'd0);

      // Ramp: 300-cycle convert strobe.
      do_reset();
      convert = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         check("ramp_code", {23'd0, dac_en, dac_code},
               {23'd0, 1'b1, (i > 255) ? 8'd255 : 8'(i)});
      end
      convert = 1'b0;
      tick(1);
      check("ramp_off", {23'd0, dac_en, dac_code}, 32'd0);

      // Sample point: third cycle of the strobe is captured.
      do_reset();
      read0 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         pix_data = 8'hA0 + 8'(i);
         tick(1);
      end
      read0 = 1'b0;
      tick(4);
      check("samp_nbeats", beats.size(), 32'd1);
      expect_beat("samp_b0", 1'b1, 2'd0, 8'hA3);

      // Backpressure over two frames.
      do_reset();
      out_ready = 1'b0;
      frame(8'h51, 8'h52, 8'h53, 8'h54);
      check("bp_hold1", {21'd0, out_valid, out_sof, out_pix, out_data}, {21'd0, 1'b1, 1'b1, 2'd0, 8'h51});
      frame(8'h61, 8'h62, 8'h63, 8'h64);
      check("bp_hold2", {21'd0, out_valid, out_sof, out_pix, out_data}, {21'd0, 1'b1, 1'b1, 2'd0, 8'h51});
      check("bp_ovr", {31'd0, overrun}, 32'd1);
      check("bp_fcnt", {24'd0, frame_cnt}, 32'd1);
      out_ready = 1'b1;
      tick(6);
      check("bp_nbeats", beats.size(), 32'd4);
      expect_beat("bp_b0", 1'b1, 2'd0, 8'h51);
      expect_beat("bp_b1", 1'b0, 2'd1, 8'h52);
      expect_beat("bp_b2", 1'b0, 2'd2, 8'h53);
      expect_beat("bp_b3", 1'b0, 2'd3, 8'h54);
      strobe(0, 2, 8'h00);
      check("bp_ovr_clr", {31'd0, overrun}, 32'd0);

      // Illegal strobe combinations.
      do_reset();
      read1 = 1'b1;
      read2 = 1'b1;
      pix_data = 8'h99;
      tick(5);
      read1 = 1'b0;
      read2 = 1'b0;
      tick(3);
      check("ill_multi_perr", {31'd0, proto_err}, 32'd1);
      check("ill_multi_valid", {31'd0, out_valid}, 32'd0);
      strobe(0, 2, 8'h00);
      check("ill_erase_clr", {31'd0, proto_err}, 32'd0);
      strobe(3, 2, 8'h77);
      tick(3);
      check("ill_short_perr", {31'd0, proto_err}, 32'd1);
      check("ill_short_valid", {31'd0, out_valid}, 32'd0);
      check("ill_nbeats", beats.size(), 32'd0);

      // Push and pop together while full.
      do_reset();
      out_ready = 1'b0;
      reads(8'h71, 8'h72, 8'h73, 8'h74);
      read0 = 1'b1;
      pix_data = 8'h81;
      tick(2);
      out_ready = 1'b1;
      tick(3);
      read0 = 1'b0;
      strobe(4, 5, 8'h82);
      strobe(5, 5, 8'h83);
      strobe(6, 5, 8'h84);
      tick(8);
      check("pp_nbeats", beats.size(), 32'd8);
      expect_beat("pp_b0", 1'b1, 2'd0, 8'h71);
      expect_beat("pp_b1", 1'b0, 2'd1, 8'h72);
      expect_beat("pp_b2", 1'b0, 2'd2, 8'h73);
      expect_beat("pp_b3", 1'b0, 2'd3, 8'h74);
      expect_beat("pp_b4", 1'b1, 2'd0, 8'h81);
      expect_beat("pp_b5", 1'b0, 2'd1, 8'h82);
      expect_beat("pp_b6", 1'b0, 2'd2, 8'h83);
      expect_beat("pp_b7", 1'b0, 2'd3, 8'h84);
      check("pp_ovr", {31'd0, overrun}, 32'd0);
      check("pp_fcnt", {24'd0, frame_cnt}, 32'd2);

      // Asynchronous reset in the middle of read2.
      do_reset();
      out_ready = 1'b0;
      strobe(0, 2, 8'h00);
      strobe(1, 2, 8'h00);
      strobe(2, 2, 8'h00);
      strobe(3, 5, 8'hB1);
      strobe(4, 5, 8'hB2);
      read2 = 1'b1;
      pix_data = 8'hB3;
      tick(2);
      check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      #2;
      check("ar_valid", {31'd0, out_valid}, 32'd0);
      check("ar_beat", {21'd0, out_sof, out_pix, out_data}, 32'd0);
      check("ar_misc", {14'd0, dac_en, dac_code, frame_cnt, overrun, proto_err}, 32'd0);
      read2 = 1'b0;
      tick(1);
      reset = 1'b0;
      beats.delete();
      out_ready = 1'b1;
      frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
      tick(4);
      check("ar_nbeats", beats.size(), 32'd4);
      expect_beat("ar_b0", 1'b1, 2'd0, 8'hC1);
      expect_beat("ar_b1", 1'b0, 2'd1, 8'hC2);
      expect_beat("ar_b2", 1'b0, 2'd2, 8'hC3);
      expect_beat("ar_b3", 1'b0, 2'd3, 8'hC4);
      check("ar_fcnt", {24'd0, frame_cnt}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
